hex_display_bank: RTL and testbench

Parametrised multi-digit hexadecimal display driver for the DE1-SoC seven-segment bank. It holds a multi-nibble value, decodes each nibble to an active-low segment pattern, and supports leading-zero blanking, a global display enable and per-digit blinking driven by an internal timebase. Any lab datapath that exposes a count, address or data word to the HEX displays instantiates it in place of per-digit decoders.

---
 rtl/hex_display_bank_if.sv | 25 ++
 rtl/hex_display_bank.sv | 114 +++++++++++
 tb/tb_hex_display_bank.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/hex_display_bank_if.sv
// Bus bundle between a lab datapath and the seven-segment display bank.
// The datapath side drives value/controls and observes the display state.
interface hex_display_bank_if #(
   parameter int NUM_DIGITS = 6
);
   logic                          load;
   logic [4*NUM_DIGITS-1:0]       value;
   logic                          display_en;
   logic                          lz_blank;
   logic                          blink_en;
   logic [NUM_DIGITS-1:0]         blink_mask;
   logic [NUM_DIGITS-1:0][6:0]    HEX;
   logic [4*NUM_DIGITS-1:0]       shown;
   logic                          blink_phase;

   modport master (
      output load, value, display_en, lz_blank, blink_en, blink_mask,
      input  HEX, shown, blink_phase
   );

   modport slave (
      input  load, value, display_en, lz_blank, blink_en, blink_mask,
      output HEX, shown, blink_phase
   );
endinterface

// File: rtl/hex_display_bank.sv
// Multi-digit hexadecimal driver for the DE1-SoC seven-segment bank.
// Latches a multi-nibble value and decodes every nibble to an active-low
// glyph, with global enable, leading-zero blanking and per-digit blinking.
module hex_display_bank #(
   parameter int NUM_DIGITS   = 6,
   parameter int BLINK_CYCLES = 25_000_000
) (
   input logic               clk,
   input logic               reset,
   hex_display_bank_if.slave bus
);

   localparam int CW = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_CYCLES - 1);
   localparam logic [6:0]    BLANK    = 7'b1111111;

   logic [4*NUM_DIGITS-1:0]    shown_q, shown_d;
   logic                       displayEn_q;
   logic                       lzBlank_q;
   logic                       blinkEn_q;
   logic [NUM_DIGITS-1:0]      blinkMask_q;
   logic [CW-1:0]              blinkCnt_q, blinkCnt_d;
   logic                       blinkPhase_q, blinkPhase_d;
   logic [NUM_DIGITS-1:0][6:0] hexOut;

   // Active-low segment pattern for one hex nibble, bit 0 = segment a.
   function automatic logic [6:0] glyph(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0: g = 7'b1000000;
         4'h1: g = 7'b1111001;
         4'h2: g = 7'b0100100;
         4'h3: g = 7'b0110000;
         4'h4: g = 7'b0011001;
         4'h5: g = 7'b0010010;
         4'h6: g = 7'b0000010;
         4'h7: g = 7'b1111000;
         4'h8: g = 7'b0000000;
         4'h9: g = 7'b0010000;
         4'hA: g = 7'b0001000;
         4'hB: g = 7'b0000011;
         4'hC: g = 7'b1000110;
         4'hD: g = 7'b0100001;
         4'hE: g = 7'b0000110;
         default: g = 7'b0001110;
      endcase
      return g;
   endfunction

   // Next shown value and blink timebase; a wrap toggles the phase on the same edge.
   always_comb begin
      shown_d      = bus.load ? bus.value : shown_q;
      blinkCnt_d   = '0;
      blinkPhase_d = 1'b1;
      if (blinkEn_q) begin
         blinkPhase_d = blinkPhase_q;
         if (blinkCnt_q == CNT_LAST) begin
            blinkCnt_d   = '0;
            blinkPhase_d = ~blinkPhase_q;
         end else begin
            blinkCnt_d = blinkCnt_q + CW'(1);
         end
      end
   end

   // State registers; reset wins over load and over the timebase.
   always_ff @(posedge clk) begin
      if (reset) begin
         shown_q      <= '0;
         displayEn_q  <= 1'b0;
         lzBlank_q    <= 1'b0;
         blinkEn_q    <= 1'b0;
         blinkMask_q  <= '0;
         blinkCnt_q   <= '0;
         blinkPhase_q <= 1'b1;
      end else begin
         shown_q      <= shown_d;
         displayEn_q  <= bus.display_en;
         lzBlank_q    <= bus.lz_blank;
         blinkEn_q    <= bus.blink_en;
         blinkMask_q  <= bus.blink_mask;
         blinkCnt_q   <= blinkCnt_d;
         blinkPhase_q <= blinkPhase_d;
      end
   end

   // Per-digit glyph selection, scanning from the most significant digit so a
   // running "all zero so far" flag identifies leading zeros; digit 0 always shows.
   always_comb begin
      logic       allZeroAbove;
      logic [3:0] nib;
      allZeroAbove = 1'b1;
      nib          = '0;
      hexOut       = '1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         nib = shown_q[4*i +: 4];
         if (!displayEn_q) begin
            hexOut[i] = BLANK;
         end else if (lzBlank_q && allZeroAbove && (nib == 4'h0) && (i != 0)) begin
            hexOut[i] = BLANK;
         end else if (blinkMask_q[i] && !blinkPhase_q) begin
            hexOut[i] = BLANK;
         end else begin
            hexOut[i] = glyph(nib);
         end
         allZeroAbove = allZeroAbove && (nib == 4'h0);
      end
   end

   assign bus.HEX         = hexOut;
   assign bus.shown       = shown_q;
   assign bus.blink_phase = blinkPhase_q;

endmodule

// File: tb/tb_hex_display_bank.sv
// Self-checking bench for hex_display_bank with 4 digits and a 4-cycle blink
// half-period; a behavioural model predicts each edge and a scoreboard compares.
module tb_hex_display_bank;

   localparam int ND = 4;
   localparam int BC = 4;
   localparam logic [6:0] BL = 7'b1111111;

   localparam logic [6:0] GLYPH [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   typedef struct {
      string       tag;
      logic [27:0] hex;
      logic [15:0] shown;
      logic        phase;
   } exp_t;

   logic clk;
   logic reset;
   int   vecCount;
   int   errCount;
   exp_t sb[$];

   // Model state
   logic [15:0] mShown;
   logic        mDen, mLz, mBen, mPhase;
   logic [3:0]  mMask;
   int          mCnt;

   hex_display_bank_if #(.NUM_DIGITS(ND)) bus ();

   hex_display_bank #(.NUM_DIGITS(ND), .BLINK_CYCLES(BC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecCount++;
      if (obs !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [27:0] modelHex();
      logic [27:0] h;
      logic        above;
      logic [3:0]  n;
      logic [6:0]  g;
      h     = '1;
      above = 1'b1;
      for (int i = ND - 1; i >= 0; i--) begin
         n = mShown[4*i +: 4];
         g = GLYPH[n];
         if (!mDen) g = BL;
         else if (mLz && above && n == 4'h0 && i != 0) g = BL;
         else if (mMask[i] && !mPhase) g = BL;
         above = above && (n == 4'h0);
         h[7*i +: 7] = g;
      end
      return h;
   endfunction

   // Drives one cycle of inputs, advances the model, pushes the prediction,
   // then pops and compares it against the DUT shortly after the edge.
   task automatic applyStimulus(input string tag, input logic rst, input logic ld,
                                input logic [15:0] val, input logic den, input logic lz,
                                input logic ben, input logic [3:0] mask);
      exp_t e, got;
      reset          = rst;
      bus.load       = ld;
      bus.value      = val;
      bus.display_en = den;
      bus.lz_blank   = lz;
      bus.blink_en   = ben;
      bus.blink_mask = mask;
      if (rst) begin
         mShown = '0; mDen = 0; mLz = 0; mBen = 0; mMask = '0; mCnt = 0; mPhase = 1;
      end else begin
         if (ld) mShown = val;
         if (mBen) begin
            if (mCnt == BC - 1) begin
               mCnt   = 0;
               mPhase = ~mPhase;
            end else begin
               mCnt++;
            end
         end else begin
            mCnt   = 0;
            mPhase = 1'b1;
         end
         mDen = den; mLz = lz; mBen = ben; mMask = mask;
      end
      e.tag = tag; e.hex = modelHex(); e.shown = mShown; e.phase = mPhase;
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      checkOutput({got.tag, ".hex"},   32'(bus.HEX),         32'(got.hex));
      checkOutput({got.tag, ".shown"}, 32'(bus.shown),       32'(got.shown));
      checkOutput({got.tag, ".phase"}, 32'(bus.blink_phase), 32'(got.phase));
   endtask

   initial begin
      vecCount = 0;
      errCount = 0;
      reset = 1'b1;
      bus.load = 0; bus.value = '0; bus.display_en = 0;
      bus.lz_blank = 0; bus.blink_en = 0; bus.blink_mask = '0;
      mShown = '0; mDen = 0; mLz = 0; mBen = 0; mMask = '0; mCnt = 0; mPhase = 1;

      // Reset state
      applyStimulus("reset", 1, 1, 16'hFFFF, 1, 1, 1, 4'hF);
      checkOutput("resetBlank", 32'(bus.HEX), 32'h0FFF_FFFF);

      // Load and display a mixed value
      applyStimulus("load1A3F", 0, 1, 16'h1A3F, 1, 0, 0, 4'h0);
      checkOutput("tp1Hex", 32'(bus.HEX),
                  32'({7'b1111001, 7'b0001000, 7'b0110000, 7'b0001110}));

      // Sweep all nibbles on digit 0
      for (int n = 0; n < 16; n++)
         applyStimulus($sformatf("sweep%0d", n), 0, 1, 16'(n), 1, 0, 0, 4'h0);

      // Leading-zero blanking
      applyStimulus("lz0050", 0, 1, 16'h0050, 1, 1, 0, 4'h0);
      checkOutput("tp3Hex", 32'(bus.HEX), 32'({BL, BL, 7'b0010010, 7'b1000000}));
      applyStimulus("lz0000", 0, 1, 16'h0000, 1, 1, 0, 4'h0);
      checkOutput("tp3Zero", 32'(bus.HEX), 32'({BL, BL, BL, 7'b1000000}));
      applyStimulus("lz1000", 0, 1, 16'h1000, 1, 1, 0, 4'h0);

      // Blinking digit 0, then deassert blink_en
      applyStimulus("blinkOn", 0, 1, 16'h1234, 1, 0, 1, 4'b0001);
      for (int c = 0; c < 3; c++)
         applyStimulus("blinkRun", 0, 0, 16'h0, 1, 0, 1, 4'b0001);
      checkOutput("blinkStillOn", 32'(bus.HEX[0]), 32'(7'b0011001));
      applyStimulus("blinkRun", 0, 0, 16'h0, 1, 0, 1, 4'b0001);
      checkOutput("blinkFirstOff", 32'(bus.HEX[0]), 32'(BL));
      for (int c = 0; c < 10; c++)
         applyStimulus("blinkRun", 0, c == 5, 16'h4321, 1, 0, 1, 4'b0001);
      applyStimulus("blinkOff", 0, 0, 16'h0, 1, 0, 0, 4'b0001);
      applyStimulus("blinkRest", 0, 0, 16'h0, 1, 0, 0, 4'b0001);

      // Reset mid-blink with load on the same edge
      for (int c = 0; c < 6; c++)
         applyStimulus("preRst", 0, 0, 16'h0, 1, 0, 1, 4'b1111);
      checkOutput("midBlinkOff", 32'(bus.blink_phase), 32'(0));
      applyStimulus("rstMid", 1, 1, 16'hBEEF, 1, 0, 1, 4'b1111);
      checkOutput("rstShown", 32'(bus.shown), 32'h0);
      checkOutput("rstPhase", 32'(bus.blink_phase), 32'h1);

      // Display disabled overrides everything; shown keeps loading
      for (int c = 0; c < 12; c++)
         applyStimulus("disabled", 0, 1, 16'($urandom), 0, 1, 1, 4'hF);

      // Random mixture
      for (int c = 0; c < 60; c++)
         applyStimulus("random", ($urandom_range(0, 19) == 0), 1'($urandom),
                       16'($urandom & 32'h0000_F0FF), ($urandom_range(0, 3) != 0),
                       1'($urandom), ($urandom_range(0, 4) != 0), 4'($urandom));

      checkOutput("sbEmpty", 32'(sb.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

endmodule
